// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared constants for the interrupt responder: source count,
//                vector-index width, controller state encoding and the
//                interrupt vector table base used by the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

   // Number of peripheral interrupt lines and width of the vector index.
   localparam int NUM_SRC = 8;
   localparam int IDX_W   = $clog2(NUM_SRC);

   // Controller state encoding.
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_REQ     = 2'b01;
   localparam logic [1:0] ST_SERVICE = 2'b10;

   // Base address of the interrupt vector table; the fetch stage adds the
   // scaled vector index to this value.
   localparam logic [31:0] IVT_BASE = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : int_prio_enc
//  Description : Combinational fixed-priority encoder. The lowest set bit of
//                req wins.
//  Ports       : req       - candidate request vector
//                any_valid - at least one bit of req is set
//                idx       - index of the winning (lowest) set bit, 0 if none
//  Revision    : 1.0  initial release
// ============================================================================
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC_P = NUM_SRC,
   parameter int IDX_W_P   = IDX_W
) (
   input  logic [NUM_SRC_P-1:0] req,
   output logic                 any_valid,
   output logic [IDX_W_P-1:0]   idx
);

   // Scan from the top down so the last assignment is the lowest set bit.
   always_comb begin
      any_valid = |req;
      idx       = '0;
      for (int i = NUM_SRC_P - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W_P'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
//  Module      : int_controller
//  Description : Interrupt responder for the pipelined core. Latches rising
//                edges of the peripheral lines as pending, arbitrates the
//                unmasked pending bits (lowest index first), presents one
//                request with a req/ack handshake and blocks further
//                requests until the core signals end-of-interrupt.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-low reset
//                irq_in     - peripheral request lines (rising-edge)
//                mask_we    - mask register write strobe
//                mask_wdata - new mask (1 = source disabled)
//                int_ack    - core took the interrupt (1-cycle pulse)
//                eoi        - core executed RTI (1-cycle pulse)
//                int_req    - interrupt request to the core
//                int_idx    - vector index of the requested source
//                pending    - pending bits (status/debug)
//                in_service - an ISR is active
//  Revision    : 1.0  initial release
// ============================================================================
module int_controller
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC_P = NUM_SRC,
   parameter int IDX_W_P   = IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC_P-1:0] irq_in,
   input  logic                 mask_we,
   input  logic [NUM_SRC_P-1:0] mask_wdata,
   input  logic                 int_ack,
   input  logic                 eoi,
   output logic                 int_req,
   output logic [IDX_W_P-1:0]   int_idx,
   output logic [NUM_SRC_P-1:0] pending,
   output logic                 in_service
);

   state_t                 state;
   logic [NUM_SRC_P-1:0]   irq_prev;
   logic [NUM_SRC_P-1:0]   mask;
   logic [NUM_SRC_P-1:0]   irq_edge;
   logic [NUM_SRC_P-1:0]   ack_clr;
   logic [NUM_SRC_P-1:0]   candidates;
   logic                   any_valid;
   logic [IDX_W_P-1:0]     enc_idx;
   logic                   take_ack;

   // irq_prev resets to 0, so a line already high at reset release is
   // treated as a fresh edge.
   assign irq_edge   = irq_in & ~irq_prev;
   assign candidates = pending & ~mask;
   assign take_ack   = (state == ST_REQ) && int_ack;

   // One-hot clear for the source being acknowledged this cycle.
   always_comb begin
      ack_clr = '0;
      if (take_ack) begin
         ack_clr[int_idx] = 1'b1;
      end
   end

   int_prio_enc #(
      .NUM_SRC_P (NUM_SRC_P),
      .IDX_W_P   (IDX_W_P)
   ) u_prio_enc (
      .req       (candidates),
      .any_valid (any_valid),
      .idx       (enc_idx)
   );

   // Edge history, mask and pending. A new edge is OR-ed in after the
   // acknowledge clear so an edge on the serviced line is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_prev <= '0;
         mask     <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~ack_clr) | irq_edge;
         if (mask_we) begin
            mask <= mask_wdata;
         end
      end
   end

   // Handshake FSM. int_idx is captured only on leaving IDLE and then held
   // until the next arbitration, so a presented request never changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         int_idx <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  int_idx <= enc_idx;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (eoi) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Decoded directly from the state register (no combinational input path).
   assign int_req    = (state == ST_REQ);
   assign in_service = (state == ST_SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_controller
//  Description : Self-checking bench for int_controller. A behavioural model
//                of the interrupt rules runs alongside the DUT and is compared
//                every cycle; directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_controller;

   logic       clk;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       int_ack;
   logic       eoi;
   logic       int_req;
   logic [2:0] int_idx;
   logic [7:0] pending;
   logic       in_service;

   int total;
   int bad;
   int req_rises;
   logic last_req;

   int_controller dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .int_ack    (int_ack),
      .eoi        (eoi),
      .int_req    (int_req),
      .int_idx    (int_idx),
      .pending    (pending),
      .in_service (in_service)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting for a candidate, 1 = request shown, 2 = ISR running
   logic [7:0] m_prev, m_pend, m_mask, m_edge, m_cand, m_next;
   logic [2:0] m_idx;
   int         m_phase;
   int         m_win;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_prev  = 8'h00;
         m_pend  = 8'h00;
         m_mask  = 8'h00;
         m_idx   = 3'd0;
         m_phase = 0;
      end else begin
         m_edge = irq_in & ~m_prev;
         m_cand = m_pend & ~m_mask;
         m_win  = -1;
         for (int i = 0; i < 8; i++) begin
            if (m_cand[i] && m_win < 0) m_win = i;
         end
         m_next = m_pend;
         if (m_phase == 1 && int_ack) m_next[m_idx] = 1'b0;
         m_next = m_next | m_edge;
         if (m_phase == 0) begin
            if (m_win >= 0) begin
               m_idx   = m_win[2:0];
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (int_ack) m_phase = 2;
         end else begin
            if (eoi) m_phase = 0;
         end
         m_pend = m_next;
         m_prev = irq_in;
         if (mask_we) m_mask = mask_wdata;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial last_req = 1'b0;
   always @(negedge clk) begin
      check("model_int_req",    {31'd0, int_req},    {31'd0, (m_phase == 1)});
      check("model_in_service", {31'd0, in_service}, {31'd0, (m_phase == 2)});
      check("model_pending",    {24'd0, pending},    {24'd0, m_pend});
      check("model_int_idx",    {29'd0, int_idx},    {29'd0, m_idx});
      if (int_req === 1'b1 && last_req !== 1'b1) req_rises++;
      last_req = int_req;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1; tick(1); int_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1; tick(1); eoi = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   int r0;

   initial begin
      total = 0; bad = 0; req_rises = 0;
      rst = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
      int_ack = 1'b0; eoi = 1'b0;
      #1 rst = 1'b0;
      #2;
      check("reset_int_req",    {31'd0, int_req},    32'd0);
      check("reset_in_service", {31'd0, in_service}, 32'd0);
      check("reset_pending",    {24'd0, pending},    32'd0);
      check("reset_int_idx",    {29'd0, int_idx},    32'd0);
      tick(2);
      rst = 1'b1;
      tick(3);

      // Single source 5
      irq_in = 8'h20; tick(1); irq_in = 8'h00;
      check("s5_pending", {24'd0, pending}, 32'h20);
      check("s5_noreq_yet", {31'd0, int_req}, 32'd0);
      tick(1);
      check("s5_req", {31'd0, int_req}, 32'd1);
      check("s5_idx", {29'd0, int_idx}, 32'd5);
      tick(2);
      pulse_ack();
      check("s5_ack_pending", {24'd0, pending}, 32'h00);
      check("s5_ack_req", {31'd0, int_req}, 32'd0);
      check("s5_ack_svc", {31'd0, in_service}, 32'd1);
      tick(5);
      pulse_eoi();
      check("s5_eoi_svc", {31'd0, in_service}, 32'd0);
      tick(2);
      check("s5_eoi_req", {31'd0, int_req}, 32'd0);

      // Simultaneous 6 and 2
      irq_in = 8'h44; tick(1); irq_in = 8'h00;
      check("p62_pending", {24'd0, pending}, 32'h44);
      tick(1);
      check("p62_idx2", {29'd0, int_idx}, 32'd2);
      pulse_ack();
      check("p62_pending40", {24'd0, pending}, 32'h40);
      pulse_eoi();
      check("p62_idle_req", {31'd0, int_req}, 32'd0);
      tick(1);
      check("p62_req6", {31'd0, int_req}, 32'd1);
      check("p62_idx6", {29'd0, int_idx}, 32'd6);
      pulse_ack();
      check("p62_pending00", {24'd0, pending}, 32'h00);
      pulse_eoi();

      // Mask hides a pending bit until unmasked
      mask_we = 1'b1; mask_wdata = 8'h01; tick(1); mask_we = 1'b0;
      irq_in = 8'h01; tick(1); irq_in = 8'h00;
      check("mask_pending", {24'd0, pending}, 32'h01);
      tick(3);
      check("mask_noreq", {31'd0, int_req}, 32'd0);
      mask_we = 1'b1; mask_wdata = 8'h00; tick(1); mask_we = 1'b0;
      check("unmask_noreq_yet", {31'd0, int_req}, 32'd0);
      tick(1);
      check("unmask_req", {31'd0, int_req}, 32'd1);
      check("unmask_idx0", {29'd0, int_idx}, 32'd0);
      pulse_ack();
      pulse_eoi();

      // Presented request is held against a higher-priority arrival
      irq_in = 8'h10; tick(1); irq_in = 8'h00;
      tick(1);
      check("hold_idx4", {29'd0, int_idx}, 32'd4);
      irq_in = 8'h02; tick(1); irq_in = 8'h00;
      check("hold_pending12", {24'd0, pending}, 32'h12);
      tick(2);
      check("hold_idx4_still", {29'd0, int_idx}, 32'd4);
      check("hold_req_still", {31'd0, int_req}, 32'd1);
      pulse_ack();
      check("hold_pending02", {24'd0, pending}, 32'h02);
      pulse_eoi();
      tick(1);
      check("hold_req1", {31'd0, int_req}, 32'd1);
      check("hold_idx1", {29'd0, int_idx}, 32'd1);
      pulse_ack();
      pulse_eoi();

      // Level held on source 3 for 50 cycles yields one request
      r0 = req_rises;
      irq_in = 8'h08;
      tick(50);
      check("level_one_rise", r0 + 1, req_rises);
      check("level_pending", {24'd0, pending}, 32'h08);
      check("level_idx3", {29'd0, int_idx}, 32'd3);
      // Ack coinciding with a fresh edge on the same source
      irq_in = 8'h00; tick(1);
      irq_in = 8'h08; int_ack = 1'b1; tick(1); int_ack = 1'b0;
      check("ackedge_pending", {24'd0, pending}, 32'h08);
      check("ackedge_svc", {31'd0, in_service}, 32'd1);
      pulse_eoi();
      check("ackedge_eoi_svc", {31'd0, in_service}, 32'd0);
      tick(1);
      check("ackedge_rereq", {31'd0, int_req}, 32'd1);
      check("ackedge_idx3", {29'd0, int_idx}, 32'd3);
      pulse_ack();
      check("ackedge_clear", {24'd0, pending}, 32'h00);
      pulse_eoi();
      irq_in = 8'h00; tick(1);

      // Asynchronous reset in the middle of a request
      irq_in = 8'h80; tick(1); irq_in = 8'h00;
      tick(1);
      check("areset_pre_req", {31'd0, int_req}, 32'd1);
      irq_in = 8'h01; tick(1); irq_in = 8'h00;
      #1 rst = 1'b0;
      #1;
      check("areset_req", {31'd0, int_req}, 32'd0);
      check("areset_pending", {24'd0, pending}, 32'd0);
      check("areset_svc", {31'd0, in_service}, 32'd0);
      check("areset_idx", {29'd0, int_idx}, 32'd0);
      tick(1);
      rst = 1'b1;
      tick(1);
      pulse_ack();
      pulse_eoi();
      tick(2);
      check("idle_ignore_req", {31'd0, int_req}, 32'd0);
      check("idle_ignore_svc", {31'd0, in_service}, 32'd0);
      check("idle_ignore_pending", {24'd0, pending}, 32'd0);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
